// File: rtl/hazard_scoreboard.sv
// Purpose: register-indexed ID-stage hazard scoreboard. Each entry counts down the cycles until
//          its pending result is readable by ID. Stall and per-operand cause are combinational
//          from the entries. A saturating stall-cycle counter serves performance monitoring.
// Latency: stall/stall_rs/stall_rt are combinational. Entries and stall_count update on the rising clk edge.
// Backpressure: a stalled ID instruction does not issue and leaves the scoreboard untouched.
//          id_flush suppresses both stall and issue.
// Build option: define HAZARD_FWD_EN when EX/MEM forwarding exists. Loads then use LOAD_USE_LAT
//          and other writes use latency 0. Otherwise every write uses WB_DIST.
// Ports: clk, rst_n (async active-low); id_* describe the ID-stage instruction;
//        stall, stall_rs, stall_rt, stall_count are the outputs.
module hazard_scoreboard #(
    parameter int REG_AW       = 5,
    parameter int WB_DIST      = 2,
    parameter int LOAD_USE_LAT = 1,
    parameter int LAT_W        = 3,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic                   id_flush,
    input  logic [REG_AW-1:0]      id_rs,
    input  logic [REG_AW-1:0]      id_rt,
    input  logic                   id_rt_used,
    input  logic [REG_AW-1:0]      id_rd,
    input  logic                   id_wr_en,
    input  logic                   id_is_load,
    output logic                   stall,
    output logic                   stall_rs,
    output logic                   stall_rt,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int NREG = 1 << REG_AW;

    logic [LAT_W-1:0] cnt [NREG];
    logic             issue;
    logic [LAT_W-1:0] issue_lat;
    logic             id_live;

    // A flushed or bubble slot can neither stall nor issue.
    assign id_live = id_valid & ~id_flush;

    always_comb begin
        stall_rs = id_live & (id_rs != '0) & (cnt[id_rs] != '0);
        stall_rt = id_live & id_rt_used & (id_rt != '0) & (cnt[id_rt] != '0);
        stall    = stall_rs | stall_rt;
        // Writes to $0 are discarded so that $0 never becomes pending.
        issue    = id_live & ~stall & id_wr_en & (id_rd != '0);
    end

`ifdef HAZARD_FWD_EN
    // ALU results are forwarded in time; only load data arrives late.
    assign issue_lat = id_is_load ? LAT_W'(LOAD_USE_LAT) : '0;
`else
    // Without forwarding, every result must go through the register file.
    logic unused_is_load;
    assign unused_is_load = id_is_load;
    assign issue_lat      = LAT_W'(WB_DIST);
`endif

    // A fresh issue overrides any pending count on the same register (WAW).
    // In-order issue means the younger latency is the one later readers depend on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (issue && (id_rd == REG_AW'(i))) begin
                    cnt[i] <= issue_lat;
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - LAT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-cycle rt-compare stall logic.
- Register-indexed scoreboard in the ID stage of the in-order MIPS pipeline. Each entry holds a countdown of the cycles until its pending result can be read by ID.
- Raises stall while an ID-stage source operand is still pending. Latencies are parametrised for the load-use case and the no-forwarding case.
- Also reports which operand caused the stall, and keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- REG_AW, 5: register address width; the scoreboard has 2**REG_AW entries.
- WB_DIST, 2: cycles from issue until ID can read a result via the register file (used when forwarding is off); range 0..2**LAT_W-1.
- LOAD_USE_LAT, 1: cycles from a load's issue until it can be forwarded to ID (used when forwarding is on); range 0..2**LAT_W-1.
- LAT_W, 3: width of each countdown entry.
- STALL_CNT_W, 16: width of stall_count.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID stage holds a real instruction (0 = bubble).
- id_flush  input  1  ID instruction is being killed this cycle (branch/jump).
- id_rs  input  REG_AW  source register rs.
- id_rt  input  REG_AW  source register rt.
- id_rt_used  input  1  rt is a read operand (0 for I-type ALU ops and loads, where rt is the destination).
- id_rd  input  REG_AW  destination register of the ID instruction.
- id_wr_en  input  1  ID instruction writes id_rd.
- id_is_load  input  1  ID instruction is a load.
- stall  output  1  hold PC and IF/ID, and inject a bubble into EX.
- stall_rs  output  1  rs is a cause of the current stall.
- stall_rt  output  1  rt is a cause of the current stall.
- stall_count  output  STALL_CNT_W  number of cycles with stall=1 since reset, saturating.

Behaviour:
- State: cnt[0..2**REG_AW-1], each LAT_W bits wide, plus stall_count.
- Reset (rst_n=0, asynchronous): all cnt entries = 0 and stall_count = 0. Consequently stall, stall_rs and stall_rt are 0.
- Cause signals are combinational from cnt and the ID inputs:
  - stall_rs = id_valid & ~id_flush & (id_rs != 0) & (cnt[id_rs] != 0).
  - stall_rt = id_valid & ~id_flush & id_rt_used & (id_rt != 0) & (cnt[id_rt] != 0).
  - stall = stall_rs | stall_rt.
- Register 0 is never a hazard, as a source or as a destination.
- Issue condition: issue = id_valid & ~id_flush & ~stall & id_wr_en & (id_rd != 0).
- Per-entry update at each rising clk edge:
  - If issue and the entry index == id_rd, the entry loads its issue latency (see Optional Feature).
  - Otherwise, if the entry != 0, it decrements by 1.
  - An entry at 0 stays at 0; there is no underflow.
- Simultaneous load and decrement on the same entry: the load wins, and the new value is not decremented that cycle.
- WAW: a write to an already-pending id_rd overwrites the entry with the new latency, even if the new value is smaller. The pipeline is in-order, so the younger value is the one any later reader needs.
- A stalled instruction does not issue and does not touch the scoreboard. All other entries keep counting down during the stall.
- id_flush=1 forces stall=0 and suppresses issue, so the flushed instruction leaves no scoreboard entry.
- Latency 0 configured: issue is a no-op on that entry, and the next instruction sees no hazard.
- A consumer directly after a producer with latency L stalls for exactly L cycles, then proceeds on cycle L+1.
- stall_count increments by 1 on each edge where stall=1. It saturates at all-ones and does not wrap.
- Reset asserted mid-stall: stall drops immediately (asynchronously), and all pending entries are lost.

Optional Feature:
- Macro: HAZARD_FWD_EN.
- Defined (forwarding present in EX/MEM):
  - Load issue latency = LOAD_USE_LAT.
  - Non-load issue latency = 0, so ALU results cause no stall.
- Undefined (no forwarding):
  - Every write, load or non-load, loads WB_DIST.
- Ports and reset behaviour are identical in both builds.

Test Plan:
- Fwd off, WB_DIST=2: add $3 issues; next ID = sub $4,$3,$5 → stall=1, stall_rs=1 for 2 cycles, then stall=0 and sub issues; stall_count=2.
- Fwd on: lw $2 issues, next ID = add $6,$7,$2 with id_rt_used=1 → stall=1 and stall_rt=1 for 1 cycle. With add $3 as producer instead: stall=0 throughout.
- Fwd off: add $0,… issues, then a reader of $0 → stall=0; scoreboard unchanged.
- Fwd on: lw $2 followed by addi $2 (WAW, latency 0), then a reader of $2 → no stall; cnt[2]=0.
- Fwd off: hazard present with id_flush=1 → stall=0, no entry loaded for the flushed dest. Separately, rst_n pulsed low mid-stall → stall=0 immediately, and a later reader of the same register → no stall.
- STALL_CNT_W=3: force 9 consecutive stall cycles → stall_count reaches 7 and holds at 7.
